conv_pingpong_ctrl: RTL

Sequencing controller for the ping-pong image row buffer (mem_bank) in the convolution path. It does three things:
- Steers incoming full-row writes into the free bank and generates the write addresses.
- Tracks which banks are full.
- When the convolution engine is ready, sweeps read row/column addresses over a full bank and emits one KERNEL_SIZE x KERNEL_SIZE window per cycle, with start and done pulses.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_window_addr_gen.sv | 60 ++++++
 rtl/conv_pingpong_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the ping-pong row-buffer sequencing controller.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, START, SWEEP, DONE} rd_state_t;

  // 0 = ping bank, 1 = pong bank
  typedef logic bank_sel_t;

  localparam int DEF_IMAGE_SIZE  = 16;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_MAX_ADDRESS = 15;

  function automatic int windows_per_bank(input int image_size, input int kernel_size,
                                          input int max_address);
    return (max_address + 2 - kernel_size) * (image_size - kernel_size + 1);
  endfunction

  localparam int WINDOWS_PER_BANK =
    windows_per_bank(DEF_IMAGE_SIZE, DEF_KERNEL_SIZE, DEF_MAX_ADDRESS);

endpackage

// File: rtl/conv_window_addr_gen.sv
// Row/column sweep counter for convolution windows over one bank, with stall
// (advance low) and a flag marking the final window of the bank.
module conv_window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMAGE_SIZE  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_SIZE   = 4,
  parameter int MAX_ADDRESS = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          advance,
  output logic [ADDR_SIZE-1:0]          rd_row,
  output logic [$clog2(IMAGE_SIZE)-1:0] rd_col,
  output logic                          last_win
);

  localparam int COL_W = $clog2(IMAGE_SIZE);
  localparam logic [ADDR_SIZE-1:0] LAST_ROW = ADDR_SIZE'(MAX_ADDRESS + 1 - KERNEL_SIZE);
  localparam logic [COL_W-1:0]     LAST_COL = COL_W'(IMAGE_SIZE - KERNEL_SIZE);

  logic [ADDR_SIZE-1:0] row_reg, row_next;
  logic [COL_W-1:0]     col_reg, col_next;
  logic                 col_end;

  assign col_end  = (col_reg == LAST_COL);
  assign last_win = col_end && (row_reg == LAST_ROW);
  assign rd_row   = row_reg;
  assign rd_col   = col_reg;

  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (load) begin
      row_next = '0;
      col_next = '0;
    end else if (advance) begin
      if (col_end) begin
        col_next = '0;
        // wrap to the origin after the final window so the next sweep starts clean
        row_next = last_win ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_reg <= '0;
      col_reg <= '0;
    end else begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

endmodule

// File: rtl/conv_pingpong_ctrl.sv
// Ping-pong row-buffer controller: steers row writes into the free bank and sweeps
// convolution windows over full banks. Optional sticky overrun flag: PINGPONG_OVERRUN_EN.
module conv_pingpong_ctrl
  import conv_pkg::*;
#(
  parameter int IMAGE_SIZE  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_SIZE   = 4,
  parameter int MAX_ADDRESS = 15,
  parameter int CNT_WIDTH   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          ready,
  output logic                          wr_ready,
  output logic                          ping_wr_en,
  output logic                          pong_wr_en,
  output logic [ADDR_SIZE-1:0]          wr_addr,
  output logic                          switch,
  output logic [ADDR_SIZE-1:0]          rd_row,
  output logic [$clog2(IMAGE_SIZE)-1:0] rd_col,
  output logic                          win_valid,
  output logic                          start,
  output logic                          bank_done,
  output logic [CNT_WIDTH-1:0]          counter
`ifdef PINGPONG_OVERRUN_EN
  ,
  output logic                          overrun
`endif
);

  localparam logic [ADDR_SIZE-1:0] LAST_WR_ADDR = ADDR_SIZE'(MAX_ADDRESS);

  rd_state_t            state_reg, state_next;
  bank_sel_t            wr_sel_reg, wr_sel_next;
  bank_sel_t            switch_reg, switch_next;
  logic [ADDR_SIZE-1:0] wr_addr_reg, wr_addr_next;
  logic [CNT_WIDTH-1:0] counter_reg, counter_next;
  logic [1:0]           full_reg, full_next;
  logic                 accept, wr_last, last_win, sweep_load, sweep_advance;

  assign wr_ready   = !full_reg[wr_sel_reg];
  assign accept     = wr_en && wr_ready;
  assign ping_wr_en = accept && (wr_sel_reg == 1'b0);
  assign pong_wr_en = accept && (wr_sel_reg == 1'b1);
  assign wr_last    = (wr_addr_reg == LAST_WR_ADDR);

  assign wr_addr = wr_addr_reg;
  assign switch  = switch_reg;
  assign counter = counter_reg;

  always_comb begin
    wr_addr_next = wr_addr_reg;
    wr_sel_next  = wr_sel_reg;
    if (accept) begin
      if (wr_last) begin
        wr_addr_next = '0;
        wr_sel_next  = ~wr_sel_reg;
      end else begin
        wr_addr_next = wr_addr_reg + 1'b1;
      end
    end
  end

  // Writer only sets the bank at wr_sel (never full), reader only clears the bank
  // at switch (always full), so the two never collide on the same bit.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
      logic set_full, clr_full;
      assign set_full      = accept && wr_last && (wr_sel_reg == 1'(gi));
      assign clr_full      = (state_reg == DONE) && (switch_reg == 1'(gi));
      assign full_next[gi] = set_full || (full_reg[gi] && !clr_full);
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    switch_next   = switch_reg;
    counter_next  = counter_reg;
    start         = 1'b0;
    bank_done     = 1'b0;
    win_valid     = 1'b0;
    sweep_load    = 1'b0;
    sweep_advance = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ready && full_reg[switch_reg]) state_next = START;
      end
      START: begin
        start      = 1'b1;
        sweep_load = 1'b1;
        state_next = SWEEP;
      end
      SWEEP: begin
        win_valid     = ready;
        sweep_advance = ready;
        if (ready && last_win) state_next = DONE;
      end
      DONE: begin
        bank_done    = 1'b1;
        switch_next  = ~switch_reg;
        counter_next = counter_reg + 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      wr_sel_reg  <= 1'b0;
      switch_reg  <= 1'b0;
      wr_addr_reg <= '0;
      counter_reg <= '0;
      full_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      wr_sel_reg  <= wr_sel_next;
      switch_reg  <= switch_next;
      wr_addr_reg <= wr_addr_next;
      counter_reg <= counter_next;
      full_reg    <= full_next;
    end
  end

  conv_window_addr_gen #(
    .IMAGE_SIZE  (IMAGE_SIZE),
    .KERNEL_SIZE (KERNEL_SIZE),
    .ADDR_SIZE   (ADDR_SIZE),
    .MAX_ADDRESS (MAX_ADDRESS)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (sweep_load),
    .advance  (sweep_advance),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .last_win (last_win)
  );

`ifdef PINGPONG_OVERRUN_EN
  logic overrun_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    overrun_reg <= 1'b0;
    else if (wr_en && !wr_ready) overrun_reg <= 1'b1;
  end

  assign overrun = overrun_reg;
`endif

endmodule
